// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: stamps each spike with the current timestep and queues it in a FWFT FIFO.
// Optional macro AER_DROP_CNT_EN builds a saturating dropped-event counter on drop_count.
module spike_aer_encoder #(
    parameter int ADDR_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spike_valid,
    input  logic                     spike,
    input  logic [ADDR_W-1:0]        neuron_idx,
    input  logic                     step_done,
    input  logic                     clr_ovf,
    output logic                     aer_valid,
    input  logic                     aer_ready,
    output logic [ADDR_W-1:0]        aer_addr,
    output logic [TS_W-1:0]          aer_ts,
    output logic [TS_W-1:0]          timestep,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = TS_W + ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TS_W-1:0]   timestep_q, timestep_d;
    logic              overflow_q, overflow_d;

    logic              push, pop, full, wr_en, drop;
    logic [WORD_W-1:0] head_word;

    assign push  = spike_valid & spike;
    assign full  = (count_q == DEPTH_C);
    assign pop   = aer_valid & aer_ready;
    // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        timestep_d = timestep_q;
        overflow_d = overflow_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (step_done) timestep_d = timestep_q + 1'b1;

        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            timestep_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timestep_q <= timestep_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {timestep_q, neuron_idx};
    end

    assign head_word  = mem_q[rd_ptr_q];
    assign aer_valid  = (count_q != '0);
    assign aer_addr   = head_word[ADDR_W-1:0];
    assign aer_ts     = head_word[WORD_W-1:ADDR_W];
    assign timestep   = timestep_q;
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign overflow   = overflow_q;

`ifdef AER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf)
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Downstream stage of the LIF neuron core. It consumes the per-neuron `spike` flag produced each time the neuron core evaluates a neuron.
- Each spike is converted into an address-event (AER) word: neuron index plus timestep stamp.
- Events are buffered in a FIFO and presented on a valid/ready stream to the router/host interface.
- Maintains the global timestep counter and reports buffer overflow.

Parameters:
- ADDR_W, 8: neuron index width.
- TS_W, 16: timestep counter and timestamp width.
- DEPTH, 16: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- spike_valid  in  1  neuron core result for neuron_idx is valid this cycle.
- spike  in  1  spike flag from neuron core; sampled only when spike_valid=1.
- neuron_idx  in  ADDR_W  index of the neuron being reported.
- step_done  in  1  single-cycle pulse marking end of the current timestep.
- clr_ovf  in  1  synchronous clear of the sticky overflow flag.
- aer_valid  out  1  head event available.
- aer_ready  in  1  consumer accepts head event.
- aer_addr  out  ADDR_W  head event neuron index.
- aer_ts  out  TS_W  head event timestep.
- timestep  out  TS_W  current timestep counter.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- fifo_full  out  1  fifo_count==DEPTH.
- overflow  out  1  sticky: at least one event dropped.
- drop_count  out  16  dropped-event counter (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: timestep=0, fifo_count=0, fifo_full=0, overflow=0, drop_count=0, aer_valid=0.
  - Internal state: read/write pointers=0.
  - Outputs take reset values immediately, without waiting for a clock edge.
  - Reset mid-transfer discards all buffered events; no partial event survives.
- Push condition: push = spike_valid & spike.
  - Stored word is {timestep, neuron_idx}, using the timestep value before any same-cycle increment.
- Pop condition: pop = aer_valid & aer_ready.
- FIFO is first-word-fall-through:
  - aer_valid = (fifo_count != 0).
  - aer_addr/aer_ts are driven from the head storage entry.
  - An event pushed at edge N is visible on aer_valid after edge N (1-cycle latency).
  - No bypass from push to output in the same cycle.
- Stream hold rule: while aer_valid=1 and aer_ready=0, aer_addr/aer_ts stay stable and aer_valid does not drop.
- Occupancy update per edge:
  - push only, not full: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both performed. This applies even when full (the pop frees the slot in the same edge).
  - push while full with no pop: event dropped, FIFO unchanged, overflow set to 1.
  - pop while empty: impossible, since aer_valid=0.
- Pointers: each pointer wraps modulo DEPTH.
- Overflow flag: cleared only by reset or clr_ovf=1.
  - If a drop and clr_ovf occur in the same cycle, the drop wins and overflow=1.
- Timestep counter:
  - Increments on each edge with step_done=1.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- step_done and push in the same cycle: the event is tagged with the old timestep.
- All arithmetic is unsigned. fifo_count is wide enough to represent DEPTH.
- Inputs are not registered; the neuron core's combinational outputs are sampled directly at the edge.

Optional Feature:
- Macro: AER_DROP_CNT_EN.
- Defined:
  - drop_count increments by 1 on each dropped event, saturating at 16'hFFFF.
  - clr_ovf also clears drop_count to 0. If a drop coincides with clr_ovf, drop_count=1.
- Undefined:
  - drop_count is tied to 0 and no counter logic is built.
  - overflow behaviour is identical in both builds.

Test Plan:
- Reset, then push spikes at idx 3, 7, 9 on consecutive cycles with aer_ready=1 and timestep=0 -> aer stream delivers (3,0), (7,0), (9,0) in order; first aer_valid appears one cycle after the first push; fifo_count returns to 0.
- aer_ready=0; push DEPTH=16 spikes idx 0..15, then idx 20 -> fifo_full=1, overflow=1, drop_count=1 (0 without macro). Releasing ready drains exactly idx 0..15; aer_addr stays stable while ready=0.
- FIFO full, same cycle push idx 5 and pop -> fifo_count stays 16, overflow stays 0, idx 5 emerges last.
- Pulse step_done together with a push of idx 2 at timestep=4 -> event stamped ts=4, timestep becomes 5; the next push is stamped 5. Separately, preload timestep=65535 via 65535 step_done pulses, then pulse once -> timestep=0.
- spike_valid=1 with spike=0 for 10 cycles -> no events, fifo_count=0. Then assert rst low mid-drain with 3 events queued -> aer_valid=0 immediately, fifo_count=0, timestep=0.
- overflow=1, assert clr_ovf in the same cycle as a drop -> overflow remains 1 and drop_count=1. Clear again with no drop -> overflow=0, drop_count=0.
